// File: rtl/dw_weight_sched.sv
// rtl/dw_weight_sched.sv - depthwise-conv weight sequencer: per-channel tap fetch then counted, handshaked replay
module dw_weight_sched #(
    parameter int DW  = 32,
    parameter int KSZ = 3,
    parameter int AW  = 16,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] cfg_base_addr,
    input  logic [CW-1:0] cfg_num_ch,
    input  logic [CW-1:0] cfg_num_pix,
    output logic          busy,
    output logic          done,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          pe_wvalid,
    input  logic          pe_wready,
    output logic [DW-1:0] pe_wdata,
    output logic          pe_wlast,
    output logic [CW-1:0] ch_idx
);

    localparam int K2 = KSZ * KSZ;
    localparam int TW = $clog2(K2 + 1);
    localparam logic [TW-1:0] K2_T   = TW'(K2);
    localparam logic [TW-1:0] LAST_T = TW'(K2 - 1);

    typedef enum logic [1:0] {IDLE, FETCH, REPLAY, FIN} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] req_cnt, rsp_cnt, tap;
    logic [CW-1:0] pix, ch, num_ch_q, num_pix_q;
    logic [AW-1:0] ch_addr;
    logic [DW-1:0] tapbuf [K2];

    logic accept, fetch_wr, last_tap, last_pix, last_ch, pe_fire;

    // A start coinciding with the done pulse belongs to the finished layer and is dropped.
    assign accept   = (state == IDLE) && start && !done;
    assign fetch_wr = (state == FETCH) && mem_rvalid && (rsp_cnt < K2_T);
    assign last_tap = (tap == LAST_T);
    assign last_pix = (pix == num_pix_q - CW'(1));
    assign last_ch  = (ch == num_ch_q - CW'(1));
    assign pe_fire  = (state == REPLAY) && pe_wready;
    assign ch_idx   = ch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        pe_wvalid = 1'b0;
        pe_wdata  = '0;
        pe_wlast  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (cfg_num_ch == '0 || cfg_num_pix == '0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (req_cnt < K2_T) begin
                    mem_req  = 1'b1;
                    mem_addr = ch_addr + AW'(req_cnt);
                end
                if (fetch_wr && rsp_cnt == LAST_T) begin
                    state_nx = REPLAY;
                end
            end
            REPLAY: begin
                busy      = 1'b1;
                pe_wvalid = 1'b1;
                pe_wdata  = tapbuf[tap];
                pe_wlast  = last_tap;
                if (pe_wready && last_tap && last_pix) begin
                    state_nx = last_ch ? FIN : FETCH;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ch_addr tracks base + ch*K2 incrementally, so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_cnt   <= '0;
            rsp_cnt   <= '0;
            tap       <= '0;
            pix       <= '0;
            ch        <= '0;
            ch_addr   <= '0;
            num_ch_q  <= '0;
            num_pix_q <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == FIN);
            if (accept) begin
                num_ch_q  <= cfg_num_ch;
                num_pix_q <= cfg_num_pix;
                ch        <= '0;
                ch_addr   <= cfg_base_addr;
                req_cnt   <= '0;
                rsp_cnt   <= '0;
                tap       <= '0;
                pix       <= '0;
            end
            if (state == FETCH && mem_req && mem_gnt) begin
                req_cnt <= req_cnt + TW'(1);
            end
            if (fetch_wr) begin
                rsp_cnt <= rsp_cnt + TW'(1);
            end
            if (pe_fire) begin
                if (!last_tap) begin
                    tap <= tap + TW'(1);
                end else begin
                    tap <= '0;
                    if (!last_pix) begin
                        pix <= pix + CW'(1);
                    end else begin
                        pix <= '0;
                        if (!last_ch) begin
                            ch      <= ch + CW'(1);
                            ch_addr <= ch_addr + AW'(K2);
                            req_cnt <= '0;
                            rsp_cnt <= '0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fetch_wr) begin
            tapbuf[rsp_cnt] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dw_weight_sched.sv
// tb/tb_dw_weight_sched.sv - directed self-checking bench for dw_weight_sched
module tb_dw_weight_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] cfg_base_addr, cfg_num_ch, cfg_num_pix;
    logic        busy, done, mem_req, pe_wvalid, pe_wlast;
    logic [15:0] mem_addr, ch_idx;
    logic        mem_gnt = 1'b1;
    logic        pe_wready = 1'b1;
    logic        mem_rvalid;
    logic [31:0] mem_rdata, pe_wdata;

    dw_weight_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_num_ch(cfg_num_ch), .cfg_num_pix(cfg_num_pix),
        .busy(busy), .done(done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .pe_wvalid(pe_wvalid), .pe_wready(pe_wready), .pe_wdata(pe_wdata), .pe_wlast(pe_wlast),
        .ch_idx(ch_idx)
    );

    always #5 clk = ~clk;

    // Memory returns data == address, two edges after the grant.
    logic        p1_v = 1'b0, p2_v = 1'b0, inj_v = 1'b0;
    logic [15:0] p1_a = '0;
    logic [31:0] p2_d = '0, inj_d = '0;
    always @(posedge clk) begin
        p1_v <= mem_req & mem_gnt;
        p1_a <= mem_addr;
        p2_v <= p1_v;
        p2_d <= {16'h0, p1_a};
    end
    assign mem_rvalid = p2_v | inj_v;
    assign mem_rdata  = inj_v ? inj_d : p2_d;

    int n_cmp = 0, n_fail = 0, cyc = 0;
    logic [15:0] addr_log[$];
    int          acyc_log[$];
    logic [31:0] wd_log[$];
    logic        wl_log[$];
    logic [15:0] wc_log[$];
    int  done_cnt, done_idx, done_beats, first_req_idx, first_beat_idx, last_rv_idx, stall_err;
    bit  req_seen, busy_seen, stall_mode = 1'b0;
    logic        prev_req = 0, prev_gnt = 0, prev_pv = 0, prev_pr = 0, prev_pl = 0;
    logic [15:0] prev_addr = '0;
    logic [31:0] prev_pd = '0;

    // Drive stall inputs for the coming edge, then log what that edge will see.
    always @(negedge clk) begin
        if (stall_mode) begin
            mem_gnt   = ~mem_gnt;
            pe_wready = ($urandom_range(0, 1) != 0);
        end else begin
            mem_gnt   = 1'b1;
            pe_wready = 1'b1;
        end
        if (rst_n) begin
            if (prev_req && !prev_gnt && (!mem_req || mem_addr !== prev_addr)) stall_err++;
            if (prev_pv && !prev_pr && (!pe_wvalid || pe_wdata !== prev_pd || pe_wlast !== prev_pl)) stall_err++;
        end
        if (mem_req && mem_gnt) begin
            addr_log.push_back(mem_addr);
            acyc_log.push_back(cyc);
        end
        if (pe_wvalid && pe_wready) begin
            wd_log.push_back(pe_wdata);
            wl_log.push_back(pe_wlast);
            wc_log.push_back(ch_idx);
        end
        if (mem_req) begin
            req_seen = 1;
            if (first_req_idx < 0) first_req_idx = cyc;
        end
        if (busy) busy_seen = 1;
        if (done) begin
            done_cnt++;
            if (done_idx < 0) done_idx = cyc;
            done_beats = wd_log.size();
        end
        if (mem_rvalid) last_rv_idx = cyc;
        if (pe_wvalid && first_beat_idx < 0) first_beat_idx = cyc;
        prev_req = mem_req; prev_gnt = mem_gnt; prev_addr = mem_addr;
        prev_pv = pe_wvalid; prev_pr = pe_wready; prev_pd = pe_wdata; prev_pl = pe_wlast;
        cyc++;
    end

    task automatic clear_logs();
        addr_log.delete(); acyc_log.delete(); wd_log.delete(); wl_log.delete(); wc_log.delete();
        done_cnt = 0; done_idx = -1; done_beats = -1; first_req_idx = -1;
        first_beat_idx = -1; last_rv_idx = -1; stall_err = 0; req_seen = 0; busy_seen = 0;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] nc, input logic [15:0] np,
                            output int c);
        @(negedge clk); #1;
        cfg_base_addr = b; cfg_num_ch = nc; cfg_num_pix = np; start = 1'b1;
        c = cyc;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) return;
        end
        n_cmp++; n_fail++;
        $display("FAIL done_timeout: got no done within %0d cycles, want a done pulse", budget);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy, done, mem_req, pe_wvalid, pe_wlast} !== 5'b0 || mem_addr !== 16'h0 ||
            pe_wdata !== 32'h0 || ch_idx !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b req=%b addr=%h wv=%b wl=%b wd=%h ch=%h, want all 0",
                     busy, done, mem_req, mem_addr, pe_wvalid, pe_wlast, pe_wdata, ch_idx);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b req=%b, want 0 0", busy, mem_req);
        end
    endtask

    task automatic test_basic();
        int c;
        clear_logs();
        do_start(16'h100, 16'd1, 16'd2, c);
        wait_done(500);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (addr_log.size() != 9) begin
            n_fail++; $display("FAIL basic_nreq: got %0d want 9", addr_log.size());
        end
        for (int i = 0; i < addr_log.size() && i < 9; i++) begin
            n_cmp++;
            if (addr_log[i] !== 16'h100 + 16'(i) || acyc_log[i] != c + i) begin
                n_fail++;
                $display("FAIL basic_addr[%0d]: got %h@%0d want %h@%0d", i, addr_log[i], acyc_log[i], 16'h100 + 16'(i), c + i);
            end
        end
        n_cmp++;
        if (wd_log.size() != 18) begin
            n_fail++; $display("FAIL basic_nbeats: got %0d want 18", wd_log.size());
        end
        for (int i = 0; i < wd_log.size() && i < 18; i++) begin
            n_cmp++;
            if (wd_log[i] !== 32'h100 + 32'(i % 9) || wl_log[i] !== (i % 9 == 8) || wc_log[i] !== 16'h0) begin
                n_fail++;
                $display("FAIL basic_beat[%0d]: got d=%h l=%b ch=%0d want d=%h l=%b ch=0", i, wd_log[i], wl_log[i], wc_log[i],
                         32'h100 + 32'(i % 9), (i % 9 == 8));
            end
        end
        n_cmp++;
        if (first_req_idx != c || first_beat_idx != last_rv_idx + 1) begin
            n_fail++;
            $display("FAIL basic_latency: got req@%0d beat@%0d lastrv@%0d want req@%0d beat@lastrv+1",
                     first_req_idx, first_beat_idx, last_rv_idx, c);
        end
        n_cmp++;
        if (done_cnt != 1 || done_beats != 18) begin
            n_fail++; $display("FAIL basic_done: got cnt=%0d beats=%0d want 1 18", done_cnt, done_beats);
        end
    endtask

    task automatic test_multi();
        int c;
        clear_logs();
        do_start(16'h0, 16'd3, 16'd1, c);
        wait_done(800);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (addr_log.size() != 27 || wd_log.size() != 27) begin
            n_fail++; $display("FAIL multi_counts: got req=%0d beats=%0d want 27 27", addr_log.size(), wd_log.size());
        end
        for (int i = 0; i < addr_log.size() && i < 27; i++) begin
            n_cmp++;
            if (addr_log[i] !== 16'(i)) begin
                n_fail++; $display("FAIL multi_addr[%0d]: got %h want %h", i, addr_log[i], 16'(i));
            end
        end
        for (int i = 0; i < wd_log.size() && i < 27; i++) begin
            n_cmp++;
            if (wd_log[i] !== 32'(i) || wl_log[i] !== (i % 9 == 8) || wc_log[i] !== 16'(i / 9)) begin
                n_fail++;
                $display("FAIL multi_beat[%0d]: got d=%h l=%b ch=%0d want d=%h l=%b ch=%0d", i, wd_log[i], wl_log[i],
                         wc_log[i], 32'(i), (i % 9 == 8), i / 9);
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_beats != 27) begin
            n_fail++; $display("FAIL multi_done: got cnt=%0d beats=%0d want 1 27", done_cnt, done_beats);
        end
    endtask

    task automatic test_stall();
        int c;
        logic [15:0] ea;
        clear_logs();
        stall_mode = 1'b1;
        do_start(16'hFFFA, 16'd2, 16'd2, c);
        wait_done(3000);
        stall_mode = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (addr_log.size() != 18 || wd_log.size() != 36) begin
            n_fail++; $display("FAIL stall_counts: got req=%0d beats=%0d want 18 36", addr_log.size(), wd_log.size());
        end
        for (int i = 0; i < addr_log.size() && i < 18; i++) begin
            ea = 16'hFFFA + 16'(i);
            n_cmp++;
            if (addr_log[i] !== ea) begin
                n_fail++; $display("FAIL stall_addr[%0d]: got %h want %h", i, addr_log[i], ea);
            end
        end
        for (int i = 0; i < wd_log.size() && i < 36; i++) begin
            ea = 16'hFFFA + 16'((i / 18) * 9 + i % 9);
            n_cmp++;
            if (wd_log[i] !== {16'h0, ea} || wl_log[i] !== (i % 9 == 8) || wc_log[i] !== 16'(i / 18)) begin
                n_fail++;
                $display("FAIL stall_beat[%0d]: got d=%h l=%b ch=%0d want d=%h l=%b ch=%0d", i, wd_log[i], wl_log[i],
                         wc_log[i], {16'h0, ea}, (i % 9 == 8), i / 18);
            end
        end
        n_cmp++;
        if (stall_err != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL stall_hold: got unstable=%0d done=%0d want 0 1", stall_err, done_cnt);
        end
    endtask

    task automatic test_empty();
        int c;
        for (int run = 0; run < 2; run++) begin
            clear_logs();
            do_start(16'h10, (run == 0) ? 16'd4 : 16'd0, (run == 0) ? 16'd0 : 16'd3, c);
            wait_done(20);
            repeat (2) @(negedge clk);
            #1;
            n_cmp++;
            if (req_seen || busy_seen || done_idx != c + 1 || done_cnt != 1) begin
                n_fail++;
                $display("FAIL empty_run%0d: got req=%b busy=%b done@%0d cnt=%0d want 0 0 done@%0d 1", run, req_seen,
                         busy_seen, done_idx, done_cnt, c + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c, k;
        clear_logs();
        do_start(16'h40, 16'd3, 16'd2, c);
        for (k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (pe_wvalid && ch_idx == 16'd1) break;
        end
        n_cmp++;
        if (k == 400) begin
            n_fail++; $display("FAIL rstmid_reach: got no REPLAY of ch 1 in 400 cycles, want it");
        end
        rst_n = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({busy, done, mem_req, pe_wvalid, pe_wlast} !== 5'b0 || mem_addr !== 16'h0 ||
            pe_wdata !== 32'h0 || ch_idx !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got busy=%b done=%b req=%b addr=%h wv=%b wl=%b wd=%h ch=%h, want all 0",
                     busy, done, mem_req, mem_addr, pe_wvalid, pe_wlast, pe_wdata, ch_idx);
        end
        rst_n = 1'b1;
        inj_v = 1'b1; inj_d = 32'hDEAD;
        @(negedge clk); #1;
        inj_v = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_abort: got done=%0d busy=%b want 0 0", done_cnt, busy);
        end
        clear_logs();
        do_start(16'h40, 16'd1, 16'd1, c);
        wait_done(300);
        n_cmp++;
        if (addr_log.size() != 9 || addr_log[0] !== 16'h40 || first_req_idx != c || wd_log.size() != 9) begin
            n_fail++;
            $display("FAIL rstmid_restart: got n=%0d a0=%h req@%0d beats=%0d want 9 0040 req@%0d 9", addr_log.size(),
                     addr_log[0], first_req_idx, wd_log.size(), c);
        end
        for (int i = 0; i < wd_log.size() && i < 9; i++) begin
            n_cmp++;
            if (wd_log[i] !== 32'h40 + 32'(i) || wc_log[i] !== 16'h0) begin
                n_fail++; $display("FAIL rstmid_beat[%0d]: got d=%h ch=%0d want d=%h ch=0", i, wd_log[i], wc_log[i], 32'h40 + 32'(i));
            end
        end
    endtask

    task automatic test_start_ignore();
        int c, c2;
        clear_logs();
        do_start(16'h0, 16'd1, 16'd1, c);
        @(negedge clk); #1;
        cfg_base_addr = 16'h500; cfg_num_ch = 16'd5; cfg_num_pix = 16'd5; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(300);
        n_cmp++;
        if (addr_log.size() != 9 || addr_log[8] !== 16'h8 || wd_log.size() != 9 || wd_log[8] !== 32'h8) begin
            n_fail++;
            $display("FAIL ignore_fetch: got n=%0d a8=%h beats=%0d d8=%h want 9 0008 9 00000008", addr_log.size(),
                     addr_log[8], wd_log.size(), wd_log[8]);
        end
        clear_logs();
        cfg_base_addr = 16'h20; cfg_num_ch = 16'd1; cfg_num_pix = 16'd1; start = 1'b1;
        @(negedge clk); #1;
        c2 = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(300);
        n_cmp++;
        if (first_req_idx != c2 || addr_log.size() != 9 || addr_log[0] !== 16'h20 || wd_log.size() != 9 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL ignore_done: got req@%0d n=%0d a0=%h beats=%0d done=%0d want req@%0d 9 0020 9 1", first_req_idx,
                     addr_log.size(), addr_log[0], wd_log.size(), done_cnt, c2);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        cfg_base_addr = '0; cfg_num_ch = '0; cfg_num_pix = '0;
        clear_logs();
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_basic();
        test_multi();
        test_stall();
        test_empty();
        test_reset_mid();
        test_start_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
